// File: rtl/btb_update_scheduler.sv
// btb_update_scheduler: shares the single BTB port between fetch lookups, buffered EX updates and a full-table invalidate walk.
// Optional build macro BTB_UPD_COALESCE_EN merges an update into the FIFO tail when the PCs match.
module btb_update_scheduler #(
    parameter int DEPTH   = 4,
    parameter int HI_WM   = 3,
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [31:0]      upd_target,
    input  logic             upd_taken,
    output logic             upd_ready,
    input  logic             lookup_req,
    output logic             lookup_gnt,
    input  logic             inval_req,
    output logic             inval_busy,
    output logic             inval_done,
    output logic             btb_wr_en,
    output logic [IDX_W-1:0] btb_wr_idx,
    output logic [31:0]      btb_wr_pc,
    output logic [31:0]      btb_wr_target,
    output logic             btb_wr_taken,
    output logic             btb_wr_clear
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]    HI   = CW'(HI_WM);
    localparam logic [CW-1:0]    FULL = CW'(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, INVAL, DONE} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] walk_q;
    logic [31:0]      pc_q  [DEPTH];
    logic [31:0]      tgt_q [DEPTH];
    logic [DEPTH-1:0] tk_q;
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             idle, walking, wr_go, push, coal, flush;

    assign idle    = state_q == IDLE;
    assign walking = state_q == INVAL;
    // Writes yield to fetch unless the FIFO is near full.
    assign wr_go   = idle & (cnt_q != '0) & (!lookup_req | cnt_q >= HI);
    assign flush   = idle & inval_req;
    assign push    = upd_valid & upd_ready;

`ifdef BTB_UPD_COALESCE_EN
    logic [PW-1:0] tail;
    assign tail = wr_q - PW'(1);
    // A tail that is also the popping head is leaving, so it cannot absorb the update.
    assign coal = push & (cnt_q != '0) & (pc_q[tail] == upd_pc) & !(wr_go & cnt_q == CW'(1));
`else
    assign coal = 1'b0;
`endif

    assign cnt_d = cnt_q + CW'(push & !coal) - CW'(wr_go);

    assign upd_ready     = idle & !inval_req & (cnt_q != FULL);
    assign lookup_gnt    = idle & lookup_req & !wr_go;
    assign inval_busy    = walking;
    assign inval_done    = state_q == DONE;
    assign btb_wr_en     = wr_go | walking;
    assign btb_wr_clear  = walking;
    assign btb_wr_idx    = walking ? walk_q : wr_go ? pc_q[rd_q][IDX_W-1:0] : '0;
    assign btb_wr_pc     = wr_go ? pc_q[rd_q] : '0;
    assign btb_wr_target = wr_go ? tgt_q[rd_q] : '0;
    assign btb_wr_taken  = wr_go & tk_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            tk_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                tgt_q[i] <= '0;
            end
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_go)
                rd_q <= rd_q + PW'(1);
            if (push & !coal) begin
                pc_q[wr_q]  <= upd_pc;
                tgt_q[wr_q] <= upd_target;
                tk_q[wr_q]  <= upd_taken;
                wr_q        <= wr_q + PW'(1);
            end
`ifdef BTB_UPD_COALESCE_EN
            if (coal) begin
                tgt_q[tail] <= upd_target;
                tk_q[tail]  <= upd_taken;
            end
`endif
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            walk_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (inval_req) begin
                    state_q <= INVAL;
                    walk_q  <= '0;
                end
                INVAL: begin
                    walk_q <= walk_q + IDX_W'(1);
                    if (walk_q == LAST)
                        state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_btb_update_scheduler.sv
// tb_btb_update_scheduler: random and directed stimulus checked against a queue-based model of the scheduler.
module tb_btb_update_scheduler;
    localparam int DEPTH = 4, HI_WM = 3, ENTRIES = 8, IDX_W = 3;

    logic clk = 1'b0, rst_n = 1'b0;
    logic upd_valid = 1'b0, upd_taken = 1'b0, lookup_req = 1'b0, inval_req = 1'b0;
    logic [31:0] upd_pc = '0, upd_target = '0;
    logic upd_ready, lookup_gnt, inval_busy, inval_done, btb_wr_en, btb_wr_taken, btb_wr_clear;
    logic [IDX_W-1:0] btb_wr_idx;
    logic [31:0] btb_wr_pc, btb_wr_target;

    btb_update_scheduler #(.DEPTH(DEPTH), .HI_WM(HI_WM), .ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .upd_ready(upd_ready), .lookup_req(lookup_req), .lookup_gnt(lookup_gnt),
        .inval_req(inval_req), .inval_busy(inval_busy), .inval_done(inval_done),
        .btb_wr_en(btb_wr_en), .btb_wr_idx(btb_wr_idx), .btb_wr_pc(btb_wr_pc),
        .btb_wr_target(btb_wr_target), .btb_wr_taken(btb_wr_taken), .btb_wr_clear(btb_wr_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
    } ent_t;

    localparam logic [73:0] RST_V = {1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    ent_t        q[$];
    int          mode, walk;
    int          n_chk = 0, n_err = 0;
    logic        m_go, m_rdy;
    logic [73:0] exp_v, obs;

    assign obs = {btb_wr_en, btb_wr_clear, btb_wr_idx, btb_wr_pc, btb_wr_target, btb_wr_taken,
                  lookup_gnt, upd_ready, inval_busy, inval_done};

    task automatic model_reset();
        q.delete();
        mode = 0;
        walk = 0;
    endtask

    // mode: 0 = accepting/draining, 1 = walking the table, 2 = walk-complete cycle
    task automatic model_eval();
        ent_t h;
        logic [IDX_W-1:0] idx;
        h = '{pc: 32'd0, tgt: 32'd0, tk: 1'b0};
        m_go  = mode == 0 && q.size() > 0 && (!lookup_req || q.size() >= HI_WM);
        m_rdy = mode == 0 && !inval_req && q.size() < DEPTH;
        if (m_go) h = q[0];
        idx = mode == 1 ? IDX_W'(walk) : h.pc[IDX_W-1:0];
        exp_v = {m_go || mode == 1, mode == 1, idx, h.pc, h.tgt, h.tk,
                 mode == 0 && lookup_req && !m_go, m_rdy, mode == 1, mode == 2};
    endtask

    task automatic model_adv();
        int  sz;
        logic coal;
        if (mode == 0) begin
            if (inval_req) begin
                q.delete();
                mode = 1;
                walk = 0;
            end else begin
                sz = q.size();
                coal = 1'b0;
`ifdef BTB_UPD_COALESCE_EN
                coal = upd_valid && m_rdy && sz > 0 && q[sz-1].pc == upd_pc && !(m_go && sz == 1);
`endif
                if (m_go) void'(q.pop_front());
                if (upd_valid && m_rdy) begin
                    if (coal) begin
                        q[q.size()-1].tgt = upd_target;
                        q[q.size()-1].tk  = upd_taken;
                    end else
                        q.push_back('{pc: upd_pc, tgt: upd_target, tk: upd_taken});
                end
            end
        end else if (mode == 1) begin
            walk++;
            if (walk == ENTRIES) mode = 2;
        end else
            mode = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk, input logic lk, input logic inv);
        upd_valid = v; upd_pc = pc; upd_target = tgt; upd_taken = tk;
        lookup_req = lk; inval_req = inv;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if (obs !== RST_V) begin n_err++; $display("FAIL reset_hold got=%h exp=%h", obs, RST_V); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        model_eval();
        n_chk++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_release got=%h exp=%h", obs, exp_v); end
        model_adv();
    endtask

    task automatic test_single();
        drive(1, 32'h100, 32'h200, 1, 0, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs !== exp_v) begin n_err++; $display("FAIL single c%0d got=%h exp=%h", c, obs, exp_v); end
            if (c == 1) begin
                n_chk++;
                if (!(btb_wr_en === 1'b1 && btb_wr_idx === 3'd0 && btb_wr_target === 32'h200 && btb_wr_taken === 1'b1)) begin
                    n_err++;
                    $display("FAIL single_write en=%b idx=%0d tgt=%h tk=%b exp en=1 idx=0 tgt=200 tk=1",
                             btb_wr_en, btb_wr_idx, btb_wr_target, btb_wr_taken);
                end
            end
            model_adv();
            drive(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_hiwm();
        for (int c = 0; c < 10; c++) begin
            drive(c < 3, 32'h300 + 32'(c * 4), $urandom, 1'($urandom), 1, 0);
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs !== exp_v) begin n_err++; $display("FAIL hiwm c%0d got=%h exp=%h", c, obs, exp_v); end
            model_adv();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 14; c++) begin
            drive(c < 8, 32'h500 + 32'(c * 4), $urandom, 1'($urandom), c < 10, 0);
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs !== exp_v) begin n_err++; $display("FAIL b2b c%0d got=%h exp=%h", c, obs, exp_v); end
            model_adv();
        end
    endtask

    task automatic test_inval();
        for (int c = 0; c < 16; c++) begin
            drive(c < 2 || c > 3, 32'h700 + 32'(c * 4), $urandom, 1'($urandom), 1, c == 2);
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs !== exp_v) begin n_err++; $display("FAIL inval c%0d got=%h exp=%h", c, obs, exp_v); end
            model_adv();
        end
    endtask

    task automatic test_reset_mid_walk();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0, 0, 0, c == 0);
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs !== exp_v) begin n_err++; $display("FAIL walk_pre c%0d got=%h exp=%h", c, obs, exp_v); end
            model_adv();
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== RST_V) begin n_err++; $display("FAIL reset_mid_walk got=%h exp=%h", obs, RST_V); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 1, 0);
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs !== exp_v) begin n_err++; $display("FAIL post_reset c%0d got=%h exp=%h", c, obs, exp_v); end
            model_adv();
        end
    endtask

    task automatic test_coalesce();
        for (int c = 0; c < 6; c++) begin
            drive(c < 2, 32'h40, 32'h900 + 32'(c), c == 1, c < 2, 0);
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs !== exp_v) begin n_err++; $display("FAIL coalesce c%0d got=%h exp=%h", c, obs, exp_v); end
            model_adv();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom), 32'h40 + 32'(4 * $urandom_range(0, 2)), $urandom, 1'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs !== exp_v) begin n_err++; $display("FAIL random c%0d got=%h exp=%h", c, obs, exp_v); end
            model_adv();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_hiwm();
        test_back_to_back();
        test_inval();
        test_reset_mid_walk();
        test_coalesce();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
